// File: rtl/tlp_xcvr_pkg.sv
// Shared transceiver types for the CPU->FPGA (C2F) chunk ring.
// The ring is 2^C2F_SIZE_NBITS bytes split into C2F_CHUNKSIZE-byte chunks
// of 64-bit words. It also holds the chunk writer's state type and its
// ring-full helper.
package tlp_xcvr_pkg;

    localparam int C2F_SIZE_NBITS  = 9;                      // 512-byte ring
    localparam int C2F_CHUNKSIZE   = 64;                     // bytes per chunk
    localparam int C2F_CHUNK_NBITS = $clog2(C2F_CHUNKSIZE);

    typedef logic [63:0] uint64;
    typedef logic [7:0]  ByteMask64;

    // Slot number within the ring, and 64-bit word offset within a slot.
    typedef logic [C2F_SIZE_NBITS-C2F_CHUNK_NBITS-1:0] C2FChunkIndex;
    typedef logic [C2F_CHUNK_NBITS-4:0]                C2FChunkOffset;

    localparam C2FChunkOffset C2F_LAST_OFFSET = C2FChunkOffset'(C2F_CHUNKSIZE / 8 - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_COMMIT
    } C2FWriterState;

    // One slot is always left empty, so a full ring is wr+1 == rd (mod slots).
    function automatic logic c2fRingFull(C2FChunkIndex wr, C2FChunkIndex rd);
        return C2FChunkIndex'(wr + 1'b1) == rd;
    endfunction

endpackage

// File: rtl/c2f_chunk_writer.sv
// C2F chunk writer: turns a valid/ready word stream into byte-masked RAM
// writes at {wrIndex, wrOffset}. It publishes wrIndex as the commit pointer
// only after the chunk's final write has had COMMIT_DELAY cycles to land.
//
// Handshake: a word is transferred on a rising sysClk edge where
// inValid && inReady. inReady is registered. It is high only in S_FILL and
// never depends combinationally on inValid. The source must hold its word
// stable until that transfer edge.
module c2f_chunk_writer
    import tlp_xcvr_pkg::*;
#(
    parameter int COMMIT_DELAY = 1  // 1..15
) (
    input  logic          sysClk,
    input  logic          sysRst,
    input  uint64         inData,
    input  ByteMask64     inMask,
    input  logic          inLast,
    input  logic          inValid,
    output logic          inReady,
    output logic          wrEnable,
    output ByteMask64     wrByteMask,
    output C2FChunkIndex  wrIndex,
    output C2FChunkOffset wrOffset,
    output uint64         wrData,
    input  C2FChunkIndex  rdIndex,
    output logic [31:0]   commitCount
);

    localparam logic [3:0] DRAIN_LAST = 4'(COMMIT_DELAY);

    C2FWriterState state;
    C2FWriterState state_next;
    C2FChunkOffset fill_offset;   // offset the next accepted word goes to
    logic [3:0]    drain_count;   // cycles spent in S_DRAIN so far
    logic          accept;
    logic          chunk_end;
    logic          do_commit;

    // Next-state and per-cycle strobes; defaults first, then per-state overrides.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        chunk_end  = 1'b0;
        do_commit  = 1'b0;
        case (state)
            S_FILL: begin
                accept    = inValid && inReady;
                // The last word slot closes the chunk whether or not inLast is set.
                chunk_end = accept && (inLast || (fill_offset == C2F_LAST_OFFSET));
                if (chunk_end) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_count == DRAIN_LAST) state_next = S_COMMIT;
            end
            S_COMMIT: begin
                // rdIndex is re-checked every cycle; there is no timeout.
                if (!c2fRingFull(wrIndex, rdIndex)) begin
                    do_commit  = 1'b1;
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // State, RAM write port, offset/index pointers and commit counter.
    // Reset discards any partial chunk; RAM contents are not touched.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state       <= S_FILL;
            inReady     <= 1'b0;
            wrEnable    <= 1'b0;
            wrByteMask  <= '0;
            wrIndex     <= '0;
            wrOffset    <= '0;
            wrData      <= '0;
            commitCount <= '0;
            fill_offset <= '0;
            drain_count <= '0;
        end else begin
            state    <= state_next;
            inReady  <= (state_next == S_FILL);
            wrEnable <= accept;
            if (accept) begin
                wrData      <= inData;
                wrByteMask  <= inMask;
                wrOffset    <= fill_offset;
                fill_offset <= fill_offset + 1'b1;
            end
            // The closing write is on the RAM port during the first S_DRAIN cycle.
            if (chunk_end) begin
                drain_count <= 4'd1;
            end else if (state == S_DRAIN) begin
                drain_count <= drain_count + 4'd1;
            end
            if (do_commit) begin
                wrIndex     <= wrIndex + 1'b1;
                fill_offset <= '0;
                commitCount <= commitCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_c2f_chunk_writer.sv
// Self-checking bench for c2f_chunk_writer. The bench keeps a byte-masked
// RAM model and a consumer that advances rdIndex. Expected writes come from
// a chunk-level reference model.
module tb_c2f_chunk_writer;
    import tlp_xcvr_pkg::*;

    localparam int D     = 1;
    localparam int WORDS = C2F_CHUNKSIZE / 8;
    localparam int SLOTS = 2 ** $bits(C2FChunkIndex);
    localparam int IW    = $bits(C2FChunkIndex);
    localparam int OW    = $bits(C2FChunkOffset);
    localparam int EW    = IW + OW + 8 + 64;

    logic          sysClk;
    logic          sysRst;
    uint64         inData;
    ByteMask64     inMask;
    logic          inLast;
    logic          inValid;
    logic          inReady;
    logic          wrEnable;
    ByteMask64     wrByteMask;
    C2FChunkIndex  wrIndex;
    C2FChunkOffset wrOffset;
    uint64         wrData;
    C2FChunkIndex  rdIndex = '0;
    logic [31:0]   commitCount;

    // Expected RAM writes: {index, offset, mask, data}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            last_we_cyc = 0;
    int            cons_bad;
    bit            auto_consume = 1'b1;
    uint64         exp_ram [SLOTS][WORDS];
    uint64         dut_ram [SLOTS][WORDS];

    // Reference model: where the next word should go and how many commits are due.
    C2FChunkIndex  m_index  = '0;
    int            m_offset = 0;
    int unsigned   m_count  = 0;
    int            seq      = 0;

    c2f_chunk_writer #(.COMMIT_DELAY(D)) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .inData      (inData),
        .inMask      (inMask),
        .inLast      (inLast),
        .inValid     (inValid),
        .inReady     (inReady),
        .wrEnable    (wrEnable),
        .wrByteMask  (wrByteMask),
        .wrIndex     (wrIndex),
        .wrOffset    (wrOffset),
        .wrData      (wrData),
        .rdIndex     (rdIndex),
        .commitCount (commitCount)
    );

    // Clock, cycle counter and watchdog.
    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    always @(posedge sysClk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic uint64 merge(input uint64 old, input uint64 d, input ByteMask64 m);
        uint64 r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Monitor: every RAM strobe must match the next expected write.
    always @(negedge sysClk) begin
        if (!sysRst && wrEnable) begin
            dut_ram[wrIndex][wrOffset] = merge(dut_ram[wrIndex][wrOffset], wrData, wrByteMask);
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ram_write", {wrIndex, wrOffset, wrByteMask, wrData}, mon_e);
            end
        end
    end

    // Consumer: reads each committed slot, checks its contents and then releases it.
    always @(negedge sysClk) begin
        if (sysRst) begin
            rdIndex = '0;
        end else if (auto_consume && rdIndex != wrIndex) begin
            cons_bad = 0;
            for (int w = 0; w < WORDS; w++)
                if (dut_ram[rdIndex][w] !== exp_ram[rdIndex][w]) cons_bad++;
            check("slot_contents", cons_bad, 0);
            rdIndex = rdIndex + 1'b1;
        end
    end

    // Drive one word, wait (bounded) for inReady, and record the expected write.
    task automatic send_word(input uint64 d, input ByteMask64 m, input logic last, input int gap);
        int t;
        repeat (gap) begin
            @(negedge sysClk);
            inValid = 1'b0;
        end
        @(negedge sysClk);
        inData  = d;
        inMask  = m;
        inLast  = last;
        inValid = 1'b1;
        t = 0;
        while (!inReady && t < 200) begin
            @(negedge sysClk);
            t++;
        end
        if (!inReady) begin
            check("ready_timeout", inReady, 1);
            inValid = 1'b0;
            return;
        end
        exp_q.push_back({m_index, C2FChunkOffset'(m_offset), m, d});
        exp_ram[m_index][m_offset] = merge(exp_ram[m_index][m_offset], d, m);
        if (last || m_offset == WORDS - 1) begin
            m_index  = m_index + 1'b1;
            m_offset = 0;
            m_count++;
        end else begin
            m_offset++;
        end
        @(posedge sysClk);
        #1 inValid = 1'b0;
    endtask

    // mode 0: sequential data, full mask, no gaps; 1: random data, mask 0F,
    // random gaps; 2: random data and mask, short random gaps.
    task automatic send_chunk(input int len, input bit use_last, input int mode);
        uint64     d;
        ByteMask64 m;
        int        gap;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: begin d = {32'hC0FFEE00 + 32'(seq), 32'(seq)}; seq++; m = 8'hFF; gap = 0; end
                1: begin d = {$urandom, $urandom}; m = 8'h0F; gap = $urandom_range(0, 3); end
                default: begin d = {$urandom, $urandom}; m = 8'($urandom); gap = $urandom_range(0, 2); end
            endcase
            send_word(d, m, use_last && (i == len - 1), gap);
        end
    endtask

    // Wait for the commit of the chunk just closed and check its timing.
    task automatic wait_commit();
        int t;
        t = 0;
        while (wrIndex !== m_index && t < 200) begin
            @(negedge sysClk);
            t++;
        end
        check("commit_index", wrIndex, m_index);
        check("commit_latency", cyc - last_we_cyc, D + 1);
        check("ready_after_commit", inReady, 1);
        check("commit_count", commitCount, m_count);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_inReady"}, inReady, 0);
        check({tag, "_wrEnable"}, wrEnable, 0);
        check({tag, "_wrByteMask"}, wrByteMask, 0);
        check({tag, "_wrIndex"}, wrIndex, 0);
        check({tag, "_wrOffset"}, wrOffset, 0);
        check({tag, "_wrData"}, wrData, 0);
        check({tag, "_commitCount"}, commitCount, 0);
    endtask

    C2FChunkIndex ring_r;

    initial begin
        for (int s = 0; s < SLOTS; s++)
            for (int w = 0; w < WORDS; w++) begin
                exp_ram[s][w] = '0;
                dut_ram[s][w] = '0;
            end
        sysRst  = 1'b1;
        inData  = '0;
        inMask  = '0;
        inLast  = 1'b0;
        inValid = 1'b0;

        // Reset state and release timing.
        repeat (3) @(negedge sysClk);
        check_outputs_zero("reset");
        sysRst = 1'b0;
        #1 check("ready_at_release", inReady, 0);
        @(negedge sysClk);
        check("ready_after_release", inReady, 1);

        // Full chunk auto-closes without inLast.
        send_chunk(WORDS, 1'b0, 0);
        wait_commit();

        // Partial chunk, then the next chunk starts at offset 0 of the next slot.
        send_chunk(3, 1'b1, 0);
        wait_commit();
        send_chunk(2, 1'b1, 0);
        wait_commit();

        // Backpressure gaps with mask 0F, then random masks and lengths.
        for (int k = 0; k < 3; k++) begin
            send_chunk($urandom_range(1, WORDS), 1'b1, 1);
            wait_commit();
        end
        for (int k = 0; k < 3; k++) begin
            send_chunk($urandom_range(1, WORDS), 1'b1, 2);
            wait_commit();
        end

        // Reset mid-chunk: partial chunk discarded, pointers back to zero.
        send_chunk(5, 1'b0, 2);
        repeat (2) @(negedge sysClk);
        check("pending_before_reset", exp_q.size(), 0);
        @(posedge sysClk);
        #2 sysRst = 1'b1;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        m_index  = '0;
        m_offset = 0;
        m_count  = 0;
        repeat (3) @(negedge sysClk);
        sysRst = 1'b0;
        send_chunk(4, 1'b1, 2);
        wait_commit();

        // Ring full: hold rdIndex and fill every free slot, then one more chunk.
        repeat (2) @(negedge sysClk);
        @(posedge sysClk);
        #1 auto_consume = 1'b0;
        check("ring_caught_up", rdIndex, m_index);
        ring_r = rdIndex;
        for (int k = 0; k < SLOTS - 1; k++) begin
            send_chunk($urandom_range(1, WORDS), 1'b1, 2);
            wait_commit();
        end
        send_chunk($urandom_range(1, WORDS), 1'b1, 2);
        repeat (20) @(negedge sysClk);
        check("ring_full_hold_index", wrIndex, C2FChunkIndex'(ring_r - 1'b1));
        check("ring_full_ready", inReady, 0);
        check("ring_full_count", commitCount, m_count - 1);
        rdIndex = ring_r + 1'b1;
        @(negedge sysClk);
        check("ring_release_index", wrIndex, ring_r);
        check("ring_release_ready", inReady, 1);
        check("ring_release_count", commitCount, m_count);
        @(posedge sysClk);
        #1 auto_consume = 1'b1;

        // A few more random chunks after the wrap.
        for (int k = 0; k < 3; k++) begin
            send_chunk($urandom_range(1, WORDS), 1'b1, 2);
            wait_commit();
        end

        repeat (20) @(negedge sysClk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("consumer_caught_up", rdIndex, wrIndex);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
